// File: rtl/bin2rns_converter.sv
// Bit-serial binary-to-RNS converter: one operand bit per cycle, all domains in parallel.
// Optional BIN2RNS_BINARY_WB_EN adds bin_wb to write bin_in straight to the binary bank.
module bin2rns_converter #(
  parameter int                       NUM_DOMAINS = 1,
  parameter logic [NUM_DOMAINS*8-1:0] MODULI      = 8'd251
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               bin_in,
  input  logic [2:0]               dst_addr,
`ifdef BIN2RNS_BINARY_WB_EN
  input  logic                     bin_wb,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [NUM_DOMAINS*8-1:0] wr_data,
  output logic [2:0]               wr_addr,
  output logic                     wr_en,
  output logic                     destination_RNS
);

  localparam int DW = NUM_DOMAINS * 8;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    WRITE
  } state_t;

  state_t          r_state;
  logic [7:0]      r_op;
  logic [2:0]      r_addr;
  logic [2:0]      r_cnt;
  logic [7:0]      r_rem [NUM_DOMAINS];
  logic            r_busy;
  logic            r_done;
  logic            r_wr_en;
  logic            r_dst;
  logic [DW-1:0]   r_wr_data;
  logic [2:0]      r_wr_addr;

  logic            w_bit;
  logic [7:0]      w_rem_nxt [NUM_DOMAINS];
  logic [DW-1:0]   w_res;

  assign w_bit = r_op[r_cnt];

  // Remainder never reaches 256 once reduced, so only the shifted value needs 9 bits.
  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
    localparam logic [8:0] M = {1'b0, MODULI[8*g +: 8]};
    logic [8:0] w_sh;
    logic [8:0] w_diff;
    assign w_sh   = {r_rem[g], w_bit};
    assign w_diff = w_sh - M;
    assign w_rem_nxt[g] = (M != 9'd0 && w_sh >= M) ? w_diff[7:0] : w_sh[7:0];
    assign w_res[8*g +: 8] = w_rem_nxt[g];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_dst     <= 1'b0;
      r_wr_data <= '0;
      r_wr_addr <= '0;
      for (int i = 0; i < NUM_DOMAINS; i++) r_rem[i] <= '0;
    end else begin
      r_done  <= 1'b0;
      r_wr_en <= 1'b0;
      r_dst   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_op   <= bin_in;
            r_addr <= dst_addr;
            r_cnt  <= 3'd7;
            r_busy <= 1'b1;
            for (int i = 0; i < NUM_DOMAINS; i++) r_rem[i] <= '0;
`ifdef BIN2RNS_BINARY_WB_EN
            if (bin_wb) begin
              r_state   <= WRITE;
              r_wr_en   <= 1'b1;
              r_done    <= 1'b1;
              r_wr_data <= DW'(bin_in);
              r_wr_addr <= dst_addr;
            end else begin
              r_state <= CONVERT;
            end
`else
            r_state <= CONVERT;
`endif
          end
        end
        CONVERT: begin
          for (int i = 0; i < NUM_DOMAINS; i++) r_rem[i] <= w_rem_nxt[i];
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            r_state   <= WRITE;
            r_wr_en   <= 1'b1;
            r_done    <= 1'b1;
            r_dst     <= 1'b1;
            r_wr_data <= w_res;
            r_wr_addr <= r_addr;
          end
        end
        WRITE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign wr_data         = r_wr_data;
  assign wr_addr         = r_wr_addr;
  assign wr_en           = r_wr_en;
  assign destination_RNS = r_dst;

endmodule

// File: tb/tb_bin2rns_converter.sv
// Bench for bin2rns_converter: three parameterisations share one stimulus and
// are checked every cycle against an arithmetic model, plus literal expectations.
module tb_bin2rns_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  bin_in;
  logic [2:0]  dst_addr;
  logic        bin_wb;

  logic        b1, d1, we1, dr1;
  logic [7:0]  wd1;
  logic [2:0]  wa1;
  logic        b2, d2, we2, dr2;
  logic [15:0] wd2;
  logic [2:0]  wa2;
  logic        b3, d3, we3, dr3;
  logic [23:0] wd3;
  logic [2:0]  wa3;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  bin2rns_converter u_d1 (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .dst_addr(dst_addr),
`ifdef BIN2RNS_BINARY_WB_EN
    .bin_wb(bin_wb),
`endif
    .busy(b1), .done(d1), .wr_data(wd1), .wr_addr(wa1),
    .wr_en(we1), .destination_RNS(dr1)
  );

  bin2rns_converter #(.NUM_DOMAINS(2), .MODULI({8'd0, 8'd1})) u_d2 (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .dst_addr(dst_addr),
`ifdef BIN2RNS_BINARY_WB_EN
    .bin_wb(bin_wb),
`endif
    .busy(b2), .done(d2), .wr_data(wd2), .wr_addr(wa2),
    .wr_en(we2), .destination_RNS(dr2)
  );

  bin2rns_converter #(.NUM_DOMAINS(3), .MODULI({8'd7, 8'd5, 8'd3})) u_d3 (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .dst_addr(dst_addr),
`ifdef BIN2RNS_BINARY_WB_EN
    .bin_wb(bin_wb),
`endif
    .busy(b3), .done(d3), .wr_data(wd3), .wr_addr(wa3),
    .wr_en(we3), .destination_RNS(dr3)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] rns(input int n, input int m0,
                                      input int m1, input int m2,
                                      input int x);
    int m [3];
    int r;
    logic [23:0] v;
    m[0] = m0; m[1] = m1; m[2] = m2;
    v = '0;
    for (int i = 0; i < n; i++) begin
      r = (m[i] == 0) ? x : x % m[i];
      v = v | (24'(r) << (8 * i));
    end
    return v;
  endfunction

  // Model: accepted edge number, mode, latched operand and held outputs.
  int          cyc = 0;
  int          acc = -1;
  bit          mwb = 0;
  logic [7:0]  mx;
  logic [2:0]  ma;
  logic [7:0]  e1 = '0;
  logic [15:0] e2 = '0;
  logic [23:0] e3 = '0;
  logic [2:0]  ea = '0;

  function automatic int mlen();
    return mwb ? 0 : 8;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      acc = -1;
      e1 = '0; e2 = '0; e3 = '0; ea = '0;
    end else begin
      if (start && (acc < 0 || cyc - acc >= mlen() + 2)) begin
        acc = cyc;
        mx  = bin_in;
        ma  = dst_addr;
`ifdef BIN2RNS_BINARY_WB_EN
        mwb = bin_wb;
`else
        mwb = 0;
`endif
      end
      if (acc >= 0 && cyc - acc == mlen()) begin
        ea = ma;
        if (mwb) begin
          e1 = mx; e2 = {8'h0, mx}; e3 = {16'h0, mx};
        end else begin
          e1 = rns(1, 251, 0, 0, int'(mx));
          e2 = 16'(rns(2, 1, 0, 0, int'(mx)));
          e3 = rns(3, 3, 5, 7, int'(mx));
        end
      end
    end
  end

  always @(negedge clk) begin
    int  d;
    bit  be, we, de;
    if (chk_en) begin
      d  = cyc - acc;
      be = (acc >= 0) && d >= 0 && d <= mlen();
      we = (acc >= 0) && d == mlen();
      de = we && !mwb;
      chk("busy1", b1, be);  chk("busy2", b2, be);  chk("busy3", b3, be);
      chk("wren1", we1, we); chk("wren2", we2, we); chk("wren3", we3, we);
      chk("done1", d1, we);  chk("done2", d2, we);  chk("done3", d3, we);
      chk("dst1", dr1, de);  chk("dst2", dr2, de);  chk("dst3", dr3, de);
      chk("data1", wd1, e1); chk("data2", wd2, e2); chk("data3", wd3, e3);
      chk("addr1", wa1, ea); chk("addr2", wa2, ea); chk("addr3", wa3, ea);
    end
  end

  task automatic do_op(input logic [7:0] x, input logic [2:0] a,
                       input bit wb, output int lat);
    @(negedge clk);
    bin_in = x; dst_addr = a; start = 1'b1; bin_wb = wb;
    @(negedge clk);
    start = 1'b0; bin_wb = 1'b0; lat = 1;
    while (!we1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!we1) chk("wren_timeout", we1, 1'b1);
  endtask

  int lat, pulses, bcnt;
  logic [7:0] cap;
  logic [2:0] capa;

  initial begin
    reset = 1'b1; start = 1'b0; bin_in = '0; dst_addr = '0; bin_wb = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_busy", b1, 1'b0);
    chk("rst_data3", wd3, 24'h0);
    chk("rst_wren", we3, 1'b0);
    reset = 1'b0;

    do_op(8'd100, 3'd5, 1'b0, lat);
    chk("t30_lat", lat, 9);
    chk("t30_data", wd3, 24'h020001);
    chk("t30_addr", wa3, 3'd5);
    chk("t30_dst", dr3, 1'b1);
    chk("t30_done", d3, 1'b1);
    chk("t30_d1", wd1, 8'd100);
    chk("t30_d2", wd2, 16'h6400);

    do_op(8'd255, 3'd1, 1'b0, lat);
    chk("t31_255", wd1, 8'd4);
    chk("t31_255_d3", wd3, 24'h030000);
    do_op(8'd250, 3'd2, 1'b0, lat);
    chk("t31_250", wd1, 8'd250);
    do_op(8'd0, 3'd3, 1'b0, lat);
    chk("t31_0", wd1, 8'd0);
    chk("t31_0_d3", wd3, 24'h0);
    do_op(8'h9C, 3'd4, 1'b0, lat);
    chk("t34_d2", wd2, 16'h9C00);
    chk("t34_d3", wd3, 24'h020100);
    @(negedge clk);
    chk("hold_wren", we1, 1'b0);
    chk("hold_data", wd1, 8'h9C);

    // Start pulses while busy and an operand change after acceptance
    @(negedge clk);
    bin_in = 8'd77; dst_addr = 3'd6; start = 1'b1;
    pulses = 0; bcnt = 0; cap = '0; capa = '0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      start = (n == 2 || n == 4 || n == 6);
      if (n == 3) begin bin_in = 8'd200; dst_addr = 3'd1; end
      if (n <= 10 && b1) bcnt++;
      if (we1) begin pulses++; cap = wd1; capa = wa1; end
    end
    chk("t32_pulses", pulses, 1);
    chk("t32_busy", bcnt, 9);
    chk("t32_data", cap, 8'd77);
    chk("t32_addr", capa, 3'd6);

    // Reset in the middle of a conversion
    @(negedge clk);
    bin_in = 8'd123; dst_addr = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t33_busy", b3, 1'b0);
    chk("t33_wren", we3, 1'b0);
    chk("t33_data", wd3, 24'h0);
    chk("t33_addr", wa3, 3'd0);
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (we1) pulses++;
    end
    chk("t33_nowr", pulses, 0);
    do_op(8'd123, 3'd7, 1'b0, lat);
    chk("t33_fresh", wd3, 24'h040300);
    chk("t33_fresh1", wd1, 8'd123);
    chk("t33_addr7", wa1, 3'd7);

    // Start held high: one conversion per ten cycles
    @(negedge clk);
    pulses = 0;
    for (int n = 0; n < 33; n++) begin
      start  = (n < 30);
      bin_in = 8'(n * 37 + 5);
      dst_addr = 3'(n);
      if (we1) pulses++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_pulses", pulses, 3);

`ifdef BIN2RNS_BINARY_WB_EN
    repeat (2) @(negedge clk);
    do_op(8'h3A, 3'd2, 1'b1, lat);
    chk("t35_lat", lat, 1);
    chk("t35_dst", dr1, 1'b0);
    chk("t35_data", wd1, 8'h3A);
    chk("t35_data3", wd3, 24'h00003A);
    chk("t35_addr", wa1, 3'd2);
    @(negedge clk);
    chk("t35_idle", b1, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
